// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the async SRAM controller: controller state encoding,
// the strobe bundle {ceb, web, oeb} and helpers that decode a state into the
// strobe levels and the data-bus drive enable.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_SETUP  = 3'd1,
      W_PULSE  = 3'd2,
      W_HOLD   = 3'd3,
      R_ACCESS = 3'd4,
      R_TURN   = 3'd5
   } state_e;

   // All three SRAM strobes are active low.
   typedef struct packed {
      logic ceb;
      logic web;
      logic oeb;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = 3'b111;

   // Strobe levels seen on the pins while the controller sits in state s.
   function automatic strobe_t strobe_for(state_e s);
      case (s)
         W_SETUP,
         W_HOLD:   return 3'b011;
         W_PULSE:  return 3'b001;
         R_ACCESS: return 3'b010;
         default:  return STROBE_IDLE;
      endcase
   endfunction

   // The controller owns the data bus only for the three write states.
   function automatic logic drives_bus(state_e s);
      return (s == W_SETUP) || (s == W_PULSE) || (s == W_HOLD);
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Turns single-word read/write requests into async SRAM strobe sequences.
// Every pin toward the SRAM is a flop output decoded from the next state, so
// there is no combinational path from req_* to sram_*.
//
// Ports
//   clk        system clock, rising edge
//   resetb     synchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted on this edge if req_valid (IDLE and not reset)
//   req_we     1 = write, 0 = read, sampled on accept
//   req_addr   word address, sampled on accept
//   req_wdata  write data, sampled on accept
//   rd_valid   one-cycle pulse when rd_data has been updated
//   rd_data    last read word, held until the next read completes
//   sram_ceb   chip enable, active low
//   sram_web   write enable, active low
//   sram_oeb   output enable, active low
//   sram_addr  SRAM address, stable for the whole transaction
//   sram_data  bidirectional data bus, driven only in write states
// -----------------------------------------------------------------------------
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 18,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  sram_ceb,
   output logic                  sram_web,
   output logic                  sram_oeb,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_data
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   // Loaded on entry so the state exits when the counter reaches zero:
   // W_PULSE lasts WAIT_CYCLES cycles, R_ACCESS lasts WAIT_CYCLES+1 cycles.
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(WAIT_CYCLES);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   strobe_t                 strobe_q;
   logic                    drive_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    rd_valid_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    accept;
   logic                    capture;

   assign req_ready = (state_q == IDLE) && resetb;
   assign accept    = req_valid && req_ready;

   // NOTE: every variable assigned here gets a default first, so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_we) begin
                  state_d = W_SETUP;
               end else begin
                  state_d = R_ACCESS;
                  cnt_d   = ACCESS_LOAD;
               end
            end
         end
         W_SETUP: begin
            state_d = W_PULSE;
            cnt_d   = PULSE_LOAD;
         end
         W_PULSE: begin
            if (cnt_q == '0) state_d = W_HOLD;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         W_HOLD: state_d = IDLE;
         R_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = R_TURN;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         R_TURN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         strobe_q   <= STROBE_IDLE;
         drive_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         // Decoding from the next state makes the pins change on the same
         // edge as the state register, with no decode glitches on the pins.
         strobe_q   <= strobe_for(state_d);
         drive_q    <= drives_bus(state_d);
         rd_valid_q <= capture;
         if (capture) rd_data_q <= sram_data;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   assign sram_ceb  = strobe_q.ceb;
   assign sram_web  = strobe_q.web;
   assign sram_oeb  = strobe_q.oeb;
   assign sram_addr = addr_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

   // Tristate kept at the top so sram_data connects straight to the pad.
   assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Two controllers share clock and reset: u_dut0 built with WAIT_CYCLES=2 and
// u_dut1 with WAIT_CYCLES=1. Each drives its own async SRAM model. Expected
// strobe counts, latencies and read data come from the transaction rules and
// a per-instance memory of written words.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

   localparam int AW    = 18;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          resetb;
   logic          req_valid [2];
   logic          req_we    [2];
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic          req_ready [2];
   logic          rd_valid  [2];
   logic [DW-1:0] rd_data   [2];
   logic          ceb       [2];
   logic          web       [2];
   logic          oeb       [2];
   logic [AW-1:0] addr_o    [2];
   wire  [DW-1:0] bus0, bus1;

   int  total = 0;
   int  bad   = 0;
   time last_acc [2];

   // Async SRAM models: drive the bus while selected and output-enabled,
   // store the bus while selected and write-enabled.
   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] mem1 [DEPTH];

   // Reference model: words written by completed write transactions.
   logic [DW-1:0] ref0 [int];
   logic [DW-1:0] ref1 [int];

   always #5 clk = ~clk;

   sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .resetb(resetb),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .sram_ceb(ceb[0]), .sram_web(web[0]), .sram_oeb(oeb[0]),
      .sram_addr(addr_o[0]), .sram_data(bus0)
   );

   sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .resetb(resetb),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .sram_ceb(ceb[1]), .sram_web(web[1]), .sram_oeb(oeb[1]),
      .sram_addr(addr_o[1]), .sram_data(bus1)
   );

   function automatic logic [DW-1:0] init_pat(int a);
      return DW'(a) ^ 16'h5A5A ^ DW'(a >>> 16);
   endfunction

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem0[a] <= init_pat(a);
         mem1[a] <= init_pat(a);
      end
   end

   assign bus0 = (!ceb[0] && !oeb[0]) ? mem0[addr_o[0]] : {DW{1'bz}};
   assign bus1 = (!ceb[1] && !oeb[1]) ? mem1[addr_o[1]] : {DW{1'bz}};

   always @(posedge clk) begin
      if (!ceb[0] && !web[0]) mem0[addr_o[0]] <= bus0;
      if (!ceb[1] && !web[1]) mem1[addr_o[1]] <= bus1;
   end

   function automatic int wait_of(int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic logic [DW-1:0] bus_of(int i);
      return (i == 0) ? bus0 : bus1;
   endfunction

   function automatic logic [DW-1:0] exp_read(int i, int a);
      if (i == 0) return ref0.exists(a) ? ref0[a] : init_pat(a);
      return ref1.exists(a) ? ref1[a] : init_pat(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Idle pin levels and handshake, sampled away from the clock edge.
   task automatic check_idle(input int i, input string tag, input logic exp_ready);
      check($sformatf("u%0d_%s_strobes", i, tag), {29'd0, ceb[i], web[i], oeb[i]}, 32'd7);
      check($sformatf("u%0d_%s_rd_valid", i, tag), 32'(rd_valid[i]), 32'd0);
      check($sformatf("u%0d_%s_ready", i, tag), 32'(req_ready[i]), 32'(exp_ready));
   endtask

   // One complete transaction. Called just after a falling edge; returns at
   // the falling edge of the IDLE cycle that follows the transaction.
   task automatic run_txn(input int i, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold_valid,
                          input bit chk_spacing);
      int w, ceb_lo, web_lo, oeb_lo, rdv_hi, rdv_at, overlap, addr_bad, data_bad, rdy_hi;
      time t_acc;
      logic [DW-1:0] exp_d;
      w = wait_of(i);
      ceb_lo = 0; web_lo = 0; oeb_lo = 0; rdv_hi = 0; rdv_at = 0;
      overlap = 0; addr_bad = 0; data_bad = 0; rdy_hi = 0;
      exp_d = we ? d : exp_read(i, int'(a));

      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = a;
      req_wdata[i] = d;
      for (int n = 0; n < 20 && !req_ready[i]; n++) @(negedge clk);
      check($sformatf("u%0d_ready_at_start", i), 32'(req_ready[i]), 32'd1);

      @(posedge clk);
      t_acc = $time;
      if (chk_spacing)
         check($sformatf("u%0d_accept_spacing", i), 32'((t_acc - last_acc[i]) / 10), 32'(w + 3));
      last_acc[i] = t_acc;
      #1;
      if (!hold_valid) req_valid[i] = 1'b0;

      for (int k = 1; k <= w + 2; k++) begin
         @(negedge clk);
         if (!ceb[i]) ceb_lo++;
         if (!web[i]) web_lo++;
         if (!oeb[i]) oeb_lo++;
         if (!web[i] && !oeb[i]) overlap++;
         if (req_ready[i]) rdy_hi++;
         if (addr_o[i] != a) addr_bad++;
         if (we && bus_of(i) != d) data_bad++;
         if (rd_valid[i]) begin
            rdv_hi++;
            rdv_at = k;
            check($sformatf("u%0d_rd_data_at_valid", i), 32'(rd_data[i]), 32'(exp_d));
         end
      end

      check($sformatf("u%0d_ceb_low_cycles", i), 32'(ceb_lo), 32'(we ? w + 2 : w + 1));
      check($sformatf("u%0d_web_low_cycles", i), 32'(web_lo), 32'(we ? w : 0));
      check($sformatf("u%0d_oeb_low_cycles", i), 32'(oeb_lo), 32'(we ? 0 : w + 1));
      check($sformatf("u%0d_rd_valid_pulses", i), 32'(rdv_hi), 32'(we ? 0 : 1));
      if (!we) check($sformatf("u%0d_rd_valid_cycle", i), 32'(rdv_at), 32'(w + 2));
      check($sformatf("u%0d_web_oeb_overlap", i), 32'(overlap), 32'd0);
      check($sformatf("u%0d_ready_while_busy", i), 32'(rdy_hi), 32'd0);
      check($sformatf("u%0d_addr_unstable", i), 32'(addr_bad), 32'd0);
      if (we) check($sformatf("u%0d_write_data_on_bus", i), 32'(data_bad), 32'd0);

      @(negedge clk);
      check_idle(i, "after_txn", 1'b1);
      check($sformatf("u%0d_rd_data_held", i), 32'(rd_data[i]),
            32'(we ? rd_data[i] ^ 16'h0 : exp_d));

      if (we) begin
         if (i == 0) ref0[int'(a)] = d;
         else        ref1[int'(a)] = d;
      end
   endtask

   // Starts a transaction on u_dut0 and pulls resetb low during cycle k_abort.
   task automatic abort_txn(input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int k_abort);
      int rdv_hi;
      rdv_hi = 0;
      req_valid[0] = 1'b1;
      req_we[0]    = we;
      req_addr[0]  = a;
      req_wdata[0] = d;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      for (int k = 1; k <= k_abort; k++) begin
         @(negedge clk);
         if (rd_valid[0]) rdv_hi++;
      end
      if (we) check("u0_mid_write_web_low", 32'(web[0]), 32'd0);
      else    check("u0_mid_read_oeb_low", 32'(oeb[0]), 32'd0);
      resetb = 1'b0;
      @(negedge clk);
      check_idle(0, "abort_edge", 1'b0);
      check("u0_abort_rd_data", 32'(rd_data[0]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rd_valid[0]) rdv_hi++;
      end
      resetb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rd_valid[0]) rdv_hi++;
      end
      check("u0_abort_no_rd_valid", 32'(rdv_hi), 32'd0);
      check_idle(0, "after_abort", 1'b1);
   endtask

   initial begin
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      bit            rw;
      int            inst;

      resetb = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         last_acc[i]  = 0;
      end

      // Reset held low for three cycles, then released.
      repeat (3) @(negedge clk);
      check_idle(0, "in_reset", 1'b0);
      check_idle(1, "in_reset", 1'b0);
      resetb = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_idle(i, "post_reset", 1'b1);
         check($sformatf("u%0d_reset_rd_data", i), 32'(rd_data[i]), 32'd0);
         check($sformatf("u%0d_reset_addr", i), 32'(addr_o[i]), 32'd0);
      end

      // Single write then read on the WAIT_CYCLES=2 controller.
      run_txn(0, 1'b1, 18'h00123, 16'hBEEF, 1'b0, 1'b0);
      run_txn(0, 1'b0, 18'h00123, 16'h0000, 1'b0, 1'b0);

      // Back-to-back stream with req_valid held high throughout.
      for (int a = 0; a < 16; a++) begin
         run_txn(0, 1'b1, AW'(a), DW'(a) ^ 16'hA5A5, 1'b1, a != 0);
         run_txn(0, 1'b0, AW'(a), 16'h0000, 1'b1, 1'b1);
      end
      req_valid[0] = 1'b0;

      // Maximum address on the WAIT_CYCLES=1 controller.
      run_txn(1, 1'b1, 18'h3FFFF, 16'h0001, 1'b0, 1'b0);
      run_txn(1, 1'b0, 18'h3FFFF, 16'h0000, 1'b0, 1'b0);

      // Random mix of reads and writes on both controllers.
      for (int n = 0; n < 40; n++) begin
         inst = int'($urandom_range(0, 1));
         rw   = 1'($urandom_range(0, 1));
         ra   = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : AW'($urandom_range(16'h100, 16'h10F));
         rd   = DW'($urandom);
         run_txn(inst, rw, ra, rd, 1'b0, 1'b0);
      end

      // Reset during W_PULSE; a different address keeps its value.
      abort_txn(1'b1, 18'h00200, 16'h1234, 2);
      run_txn(0, 1'b0, 18'h00005, 16'h0000, 1'b0, 1'b0);

      // Reset during R_ACCESS; the following read completes normally.
      abort_txn(1'b0, 18'h00007, 16'h0000, 2);
      run_txn(0, 1'b0, 18'h00007, 16'h0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
